pipe_stall_ctrl: RTL and testbench

- Sequencing controller for a chain of stallable pipeline register stages in the convolution datapath. These are data, done and co_filter registers that share one enable, driven as !stall.
- Accepts a run of `len` items from the upstream feeder and tracks per-stage occupancy.
- Generates the shared stall from downstream back-pressure, tags the last item and filter-switch items, and pulses done once the pipeline has drained.

---
 rtl/pipe_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Sequencing and stall control for a chain of DEPTH stallable register stages sharing one enable (!stall).
// Optional: define STALL_CNT_EN to add the saturating stall_cycles counter output.
module pipe_stall_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             filter_switch,
  input  logic             out_ready,
  output logic             stall,
  output logic             valid_out,
  output logic             done_tag,
  output logic             co_filter_tag,
  output logic             busy,
  output logic             done
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] vld_p;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] len_q;
  logic             accept;
  logic             last_item;
  logic             start_ok;

  assign start_ok  = (state == IDLE) & start;
  assign valid_out = vld_p[DEPTH-1];
  assign stall     = vld_p[DEPTH-1] & ~out_ready;
  assign in_ready  = (state == RUN) & ~stall & (issued < len_q);
  assign accept    = in_valid & in_ready;
  assign last_item = (issued == (len_q - CNT_W'(1)));

  // launch-side tags travel with the item entering stage 0
  assign done_tag      = accept & last_item;
  assign co_filter_tag = accept & filter_switch;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((accept && last_item) || (issued >= len_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_p == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      issued <= '0;
      len_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q  <= len;
        issued <= '0;
      end else if (accept) begin
        issued <= issued + CNT_W'(1);
      end
    end
  end

  // stage occupancy: advances as one shift register, frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p[0] <= accept;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

`ifdef STALL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_cycles <= '0;
    end else if (stall && busy) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: accept/retire scoreboard plus cycle-exact done timing checks.
module tb_pipe_stall_ctrl;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             filter_switch;
  logic             out_ready;
  logic             stall;
  logic             valid_out;
  logic             done_tag;
  logic             co_filter_tag;
  logic             busy;
  logic             done;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  pipe_stall_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .filter_switch(filter_switch),
    .out_ready(out_ready), .stall(stall), .valid_out(valid_out),
    .done_tag(done_tag), .co_filter_tag(co_filter_tag), .busy(busy), .done(done)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_idx = 0;
  int run_len = 0;
  int fs_idx = 99;
  int retires = 0;
  int done_cnt = 0;
  int pre_n = 0;
  int pre_extra = 0;
  int acc_q[$];
  int lat_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepts push their cycle and expected latency, retires pop and compare.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (in_valid && in_ready) begin
        chk("accept_in_range", 32'(acc_idx < run_len), 1);
        chk("done_tag", 32'(done_tag), 32'(acc_idx == run_len - 1));
        chk("co_filter_tag", 32'(co_filter_tag), 32'(acc_idx == fs_idx));
        acc_q.push_back(cyc);
        lat_q.push_back((acc_idx < pre_n) ? DEPTH + pre_extra : DEPTH);
        acc_idx++;
      end else begin
        chk("done_tag_no_accept", 32'(done_tag), 0);
        chk("co_filter_tag_no_accept", 32'(co_filter_tag), 0);
      end
      if (valid_out && out_ready) begin
        chk("retire_pending", 32'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) begin
          int a;
          int l;
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          chk("latency", 32'(cyc - a), 32'(l));
        end
        retires++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_quiet(input string tag);
    chk(tag, 32'({in_ready, stall, valid_out, done_tag, co_filter_tag, busy, done}), 0);
  endtask

  // Drives one run from its start cycle (k=0) until done, then one idle cycle.
  task automatic run(input int l, input int fs_cyc, input int stall_from, input int stall_len,
                     input int s2_cyc, input int s2_len, input int n_pre, input int extra,
                     input int exp_done, input int max_cyc);
    int d0;
    int done_at;
    run_len   = l;
    fs_idx    = fs_cyc - 1;
    pre_n     = n_pre;
    pre_extra = extra;
    acc_idx   = 0;
    retires   = 0;
    acc_q.delete();
    lat_q.delete();
    d0      = done_cnt;
    done_at = -1;
    for (int k = 0; k < max_cyc && done_at < 0; k++) begin
      @(posedge clk); #1;
      start         = (k == 0) || (k == s2_cyc);
      len           = (k == 0) ? CNT_W'(l) : CNT_W'(s2_len);
      in_valid      = 1'b1;
      filter_switch = (k == fs_cyc) || (k == fs_cyc + 2);
      out_ready     = !(k >= stall_from && k < stall_from + stall_len);
      @(negedge clk);
      if (!out_ready) begin
        chk("stall_asserted", 32'(stall), 1);
        chk("in_ready_during_stall", 32'(in_ready), 0);
        chk("valid_held_during_stall", 32'(valid_out), 1);
      end
      if (done) done_at = k;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; filter_switch = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("done_cycle", 32'(done_at), 32'(exp_done));
    chk("idle_after_done", 32'({busy, done}), 0);
    chk("accept_count", 32'(acc_idx), 32'(l));
    chk("retire_count", 32'(retires), 32'(l));
    chk("done_pulses", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    filter_switch = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_idle");
`ifdef STALL_CNT_EN
    chk("stall_cycles_reset", 32'(stall_cycles), 0);
`endif

    // len=3, free flowing: accepts at 1..3, last retire 5, v empty 6, done 7
    run(3, 100, 100, 0, 100, 0, 0, 0, 7, 40);
`ifdef STALL_CNT_EN
    chk("stall_cycles_none", 32'(stall_cycles), 0);
`endif

    // len=4, out_ready low cycles 3..7: first two items wait 5 extra cycles
    run(4, 100, 3, 5, 100, 0, 2, 5, 13, 60);
`ifdef STALL_CNT_EN
    chk("stall_cycles_five", 32'(stall_cycles), 5);
`endif

    // len=0 goes straight to DONE
    run(0, 100, 100, 0, 100, 0, 0, 0, 1, 20);

    // filter_switch on 2nd accept (cycle 2) and again at cycle 4 when in_ready=0
    run(3, 2, 100, 0, 100, 0, 0, 0, 7, 40);

    // reset with two items in flight
    run_len = 4; fs_idx = 99; pre_n = 0; acc_idx = 0; retires = 0;
    acc_q.delete(); lat_q.delete();
    @(posedge clk); #1;
    start = 1'b1; len = CNT_W'(4); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("two_in_flight", 32'({valid_out, busy}), 32'(2'b11));
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("after_midrun_reset");
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("no_done_after_reset", 32'(done_cnt - d0), 0);
      chk("idle_after_reset", 32'(busy), 0);
    end
    run(1, 100, 100, 0, 100, 0, 0, 0, 5, 30);

    // start with len=7 during DRAIN is ignored
    run(3, 100, 100, 0, 5, 7, 0, 0, 7, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
